// File: rtl/ram_handshake_ctrl.sv
// Byte-addressed big-endian memory behind an MFA/MOC handshake with a fixed
// number of wait states; byte/halfword/word accesses with alignment checking.
module ram_handshake_ctrl #(
  parameter int DEPTH   = 512,
  parameter int AW      = 9,
  parameter int LATENCY = 2
) (
  input  logic          Clk,
  input  logic          Clear,
  input  logic          MFA,
  input  logic          ReadWrite,
  input  logic [1:0]    DataSize,
  input  logic          SignExt,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   DataIn,
  output logic [31:0]   DataOut,
  output logic          MOC,
  output logic          Misalign
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  logic [7:0] Mem [0:DEPTH-1];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] r_addr;
  logic          r_rw;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [31:0]   r_din;
  logic [31:0]   r_dout;
  logic          r_moc;
  logic          r_mis;

  logic          w_capture;
  logic          w_complete;
  logic          w_release;
  logic [AW-1:0] w_addr;
  logic          w_rw;
  logic [1:0]    w_size;
  logic          w_sext;
  logic [31:0]   w_din;
  logic [7:0]    w_b0, w_b1, w_b2, w_b3;
  logic [31:0]   w_rd_data;
  logic          w_mis;
  logic          w_wr_en;

  // With LATENCY=1 completion happens on the capture edge, so live inputs are used in IDLE.
  assign w_addr = (r_state == S_IDLE) ? Address   : r_addr;
  assign w_rw   = (r_state == S_IDLE) ? ReadWrite : r_rw;
  assign w_size = (r_state == S_IDLE) ? DataSize  : r_size;
  assign w_sext = (r_state == S_IDLE) ? SignExt   : r_sext;
  assign w_din  = (r_state == S_IDLE) ? DataIn    : r_din;

  assign w_b0 = Mem[w_addr];
  assign w_b1 = Mem[w_addr + AW'(1)];
  assign w_b2 = Mem[w_addr + AW'(2)];
  assign w_b3 = Mem[w_addr + AW'(3)];

  // Big-endian read assembly with optional sign extension.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (w_size)
      2'b00:   w_rd_data = {{24{w_sext & w_b0[7]}}, w_b0};
      2'b01:   w_rd_data = {{16{w_sext & w_b0[7]}}, w_b0, w_b1};
      default: w_rd_data = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  // Alignment check; reserved size behaves as word.
  always_comb begin
    w_mis = 1'b0;
    case (w_size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = w_addr[0];
      default: w_mis = |w_addr[1:0];
    endcase
  end

  assign w_wr_en = w_complete & ~w_rw & ~w_mis;

  // Next-state and handshake event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MFA) begin
          w_capture = 1'b1;
          if (LATENCY == 1) begin
            w_complete  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = CW'(LATENCY - 1);
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        if (!MFA) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_din   <= 32'h0000_0000;
      r_dout  <= 32'h0000_0000;
      r_moc   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr <= Address;
        r_rw   <= ReadWrite;
        r_size <= DataSize;
        r_sext <= SignExt;
        r_din  <= DataIn;
      end
      if (w_complete) begin
        r_moc <= 1'b1;
        r_mis <= w_mis;
        if (w_rw && !w_mis) begin
          r_dout <= w_rd_data;
        end
      end else if (w_release) begin
        r_moc <= 1'b0;
        r_mis <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset so preloaded contents survive Clear.
  always_ff @(posedge Clk) begin
    if (!Clear && w_wr_en) begin
      case (w_size)
        2'b00: Mem[w_addr] <= w_din[7:0];
        2'b01: begin
          Mem[w_addr]          <= w_din[15:8];
          Mem[w_addr + AW'(1)] <= w_din[7:0];
        end
        default: begin
          Mem[w_addr]          <= w_din[31:24];
          Mem[w_addr + AW'(1)] <= w_din[23:16];
          Mem[w_addr + AW'(2)] <= w_din[15:8];
          Mem[w_addr + AW'(3)] <= w_din[7:0];
        end
      endcase
    end
  end

  assign DataOut  = r_dout;
  assign MOC      = r_moc;
  assign Misalign = r_mis;

endmodule
